// File: rtl/maxpool_1d_stream.sv
// Streaming non-overlapping 1-D max-pool: reduces each window of P signed samples
// to its maximum; beats past the last full window in a frame are consumed and dropped.
module maxpool_1d_stream #(
    parameter int WIDTH = 16,
    parameter int N     = 11,
    parameter int P     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_data,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             frame_done
);

    localparam int OUT_N = N / P;
    localparam int KEEP  = OUT_N * P;
    localparam int CW    = $clog2(N + 1);
    localparam int WW    = (P > 2) ? $clog2(P) : 1;
    localparam int OW    = $clog2(OUT_N + 1);

    localparam logic [CW-1:0] C_LAST_IN  = CW'(N - 1);
    localparam logic [CW-1:0] C_KEEP     = CW'(KEEP);
    localparam logic [WW-1:0] C_LAST_WIN = WW'(P - 1);
    localparam logic [OW-1:0] C_LAST_OUT = OW'(OUT_N - 1);

    logic [CW-1:0]    r_in_cnt;
    logic [WW-1:0]    r_win_cnt;
    logic [OW-1:0]    r_out_cnt;
    logic [WIDTH-1:0] r_run_max;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_valid;
    logic             r_frame_done;

    logic             w_in_pool;
    logic             w_win_first;
    logic             w_win_last;
    logic             w_completing;
    logic             w_x_fire;
    logic             w_y_fire;
    logic             w_load;
    logic             w_x_gt;
    logic [WIDTH-1:0] w_win_max;

    always_comb begin
        w_in_pool    = (r_in_cnt < C_KEEP);
        w_win_first  = (r_win_cnt == '0);
        w_win_last   = (r_win_cnt == C_LAST_WIN);
        w_completing = w_in_pool && w_win_last;
        // Only a window-closing beat needs the output slot, so only it can stall.
        x_ready      = !(w_completing && r_y_valid && !y_ready);
        w_x_fire     = x_valid && x_ready;
        w_y_fire     = r_y_valid && y_ready;
        w_load       = w_x_fire && w_completing;
        w_x_gt       = ($signed(x_data) > $signed(r_run_max));
        w_win_max    = w_x_gt ? x_data : r_run_max;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_cnt  <= '0;
            r_win_cnt <= '0;
            r_run_max <= '0;
        end else if (w_x_fire) begin
            if (r_in_cnt == C_LAST_IN) begin
                r_in_cnt  <= '0;
                r_win_cnt <= '0;
            end else begin
                r_in_cnt <= r_in_cnt + 1'b1;
                if (w_in_pool) begin
                    r_win_cnt <= w_win_last ? '0 : r_win_cnt + 1'b1;
                end
            end
            if (w_in_pool) begin
                r_run_max <= w_win_first ? x_data : w_win_max;
            end
        end
    end

    // Single-entry output slot; a same-cycle load and drain keeps y_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
        end else if (w_load) begin
            r_y_data  <= w_win_max;
            r_y_valid <= 1'b1;
        end else if (w_y_fire) begin
            r_y_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_y_fire && (r_out_cnt == C_LAST_OUT);
            if (w_y_fire) begin
                r_out_cnt <= (r_out_cnt == C_LAST_OUT) ? '0 : r_out_cnt + 1'b1;
            end
        end
    end

    assign y_data     = r_y_data;
    assign y_valid    = r_y_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Directed cycle-table bench for maxpool_1d_stream (N=11, P=2, WIDTH=16).
module tb_maxpool_1d_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic        frame_done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        xv;
        logic [15:0] xd;
        logic        yr;
        logic        xr;
        logic        yv;
        logic [15:0] yd;
        logic        fd;
    } vec_t;

    vec_t vq[$];
    logic [15:0] cur_x[11];
    logic [15:0] cur_y[5];

    maxpool_1d_stream #(.WIDTH(16), .N(11), .P(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_data     (x_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .y_data     (y_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, got, exp);
    endtask

    function automatic void add(input logic xv, input int xd, input logic yr,
                                input logic xr, input logic yv, input int yd, input logic fd);
        vec_t v;
        v.xv = xv; v.xd = 16'(xd); v.yr = yr;
        v.xr = xr; v.yv = yv; v.yd = 16'(yd); v.fd = fd;
        vq.push_back(v);
    endfunction

    // Continuous frames at full rate with y_ready=1: output j of frame f is
    // visible at cycle 11f+2j+2, frame_done at cycle 11f+11.
    function automatic void add_frames(input int nfr);
        for (int c = 0; c < nfr * 11 + 2; c++) begin
            logic yv;
            int   yd;
            logic fd;
            yv = 1'b0;
            yd = 0;
            fd = (c >= 11) && (c % 11 == 0) && (c / 11 <= nfr);
            for (int f = 0; f < nfr; f++)
                for (int j = 0; j < 5; j++)
                    if (c == f * 11 + 2 * j + 2) begin
                        yv = 1'b1;
                        yd = int'($signed(cur_y[j]));
                    end
            if (c < nfr * 11) add(1'b1, int'(cur_x[c % 11]), 1'b1, 1'b1, yv, yd, fd);
            else              add(1'b0, 0, 1'b1, 1'b1, yv, yd, fd);
        end
    endfunction

    task automatic run_vecs(input string name, input int exp_takes);
        int takes;
        takes = 0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            x_valid = vq[i].xv;
            x_data  = vq[i].xd;
            y_ready = vq[i].yr;
            #1;
            chk($sformatf("%s[%0d] x_ready", name, i), 32'(x_ready), 32'(vq[i].xr));
            chk($sformatf("%s[%0d] y_valid", name, i), 32'(y_valid), 32'(vq[i].yv));
            chk($sformatf("%s[%0d] frame_done", name, i), 32'(frame_done), 32'(vq[i].fd));
            if (vq[i].yv)
                chk($sformatf("%s[%0d] y_data", name, i), 32'($signed(y_data)), 32'($signed(vq[i].yd)));
            if (y_valid && vq[i].yr) begin
                takes++;
                $display("%s: cycle %0d output %0d taken", name, i, $signed(y_data));
            end
        end
        chk($sformatf("%s handshakes", name), 32'(takes), 32'(exp_takes));
        vq.delete();
    endtask

    task automatic load_basic();
        cur_x = '{16'd0, 16'd5, 16'd3, 16'd3, 16'd7, 16'd2, 16'd0, 16'd0, 16'd9, 16'd10, 16'd4};
        cur_y = '{16'd5, 16'd3, 16'd7, 16'd0, 16'd10};
    endtask

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        x_data  = '0;
        y_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset y_valid", 32'(y_valid), 32'd0);
        chk("reset y_data", 32'(y_data), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset x_ready", 32'(x_ready), 32'd1);

        load_basic();
        add_frames(1);
        run_vecs("basic", 5);

        cur_x = '{-16'sd3, -16'sd1, -16'sd32768, 16'sd32767, 16'sd100, -16'sd100,
                  16'sd1, 16'sd2, 16'sd0, 16'sd0, 16'sd7};
        cur_y = '{-16'sd1, 16'sd32767, 16'sd100, 16'sd2, 16'sd0};
        add_frames(1);
        run_vecs("signed", 5);

        //  xv  xd  yr  xr  yv  yd  fd
        add(1,  0, 1, 1, 0,  0, 0);
        add(1,  5, 1, 1, 0,  0, 0);
        add(1,  3, 0, 1, 1,  5, 0);
        add(1,  3, 0, 0, 1,  5, 0);
        add(1,  3, 0, 0, 1,  5, 0);
        add(1,  3, 1, 1, 1,  5, 0);
        add(1,  7, 1, 1, 1,  3, 0);
        add(1,  2, 1, 1, 0,  0, 0);
        add(1,  0, 1, 1, 1,  7, 0);
        add(1,  0, 1, 1, 0,  0, 0);
        add(1,  9, 1, 1, 1,  0, 0);
        add(1, 10, 1, 1, 0,  0, 0);
        add(1,  4, 1, 1, 1, 10, 0);
        add(0,  0, 1, 1, 0,  0, 1);
        add(0,  0, 1, 1, 0,  0, 0);
        run_vecs("backpressure", 5);

        add(1,  0, 1, 1, 0,  0, 0);
        add(1,  5, 1, 1, 0,  0, 0);
        add(1,  3, 0, 1, 1,  5, 0);
        add(1,  3, 1, 1, 1,  5, 0);
        add(1,  7, 1, 1, 1,  3, 0);
        add(1,  2, 1, 1, 0,  0, 0);
        add(1,  0, 1, 1, 1,  7, 0);
        add(1,  0, 1, 1, 0,  0, 0);
        add(1,  9, 1, 1, 1,  0, 0);
        add(1, 10, 1, 1, 0,  0, 0);
        add(1,  4, 1, 1, 1, 10, 0);
        add(0,  0, 1, 1, 0,  0, 1);
        add(0,  0, 1, 1, 0,  0, 0);
        run_vecs("drain_load", 5);

        load_basic();
        add_frames(2);
        run_vecs("back_to_back", 10);

        add(1,  0, 1, 1, 0,  0, 0);
        add(1,  5, 1, 1, 0,  0, 0);
        add(1,  3, 1, 1, 1,  5, 0);
        add(1,  3, 1, 1, 0,  0, 0);
        add(1,  7, 0, 1, 1,  3, 0);
        run_vecs("pre_reset", 1);

        @(negedge clk);
        x_valid = 1'b0;
        y_ready = 1'b0;
        #1;
        chk("pre_reset held y_valid", 32'(y_valid), 32'd1);
        chk("pre_reset held y_data", 32'(y_data), 32'd3);
        reset = 1'b1;
        #1;
        chk("async reset y_valid", 32'(y_valid), 32'd0);
        chk("async reset frame_done", 32'(frame_done), 32'd0);
        chk("async reset y_data", 32'(y_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        y_ready = 1'b1;
        #1;
        chk("post_reset y_valid", 32'(y_valid), 32'd0);
        chk("post_reset x_ready", 32'(x_ready), 32'd1);

        load_basic();
        add_frames(1);
        run_vecs("after_reset", 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
